execute: RTL and testbench

//   Execute stage of the single-cycle RV64 core; decode and register read sit upstream.
//   - Performs the ALU operation selected by a 4-bit control code.
//   - Resolves BEQ-style branches and computes next_PC.
//   - Owns the architectural PC register, updated every clock.

---
 rtl/execute_pkg.sv | 17 +
 rtl/exec_alu_core.sv | 32 +++
 rtl/execute.sv | 48 ++++
 tb/tb_execute.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// Shared constants for the RV64 execute stage: datapath width, ALU op codes, PC step.
package execute_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/exec_alu_core.sv
// Combinational ALU for the execute stage; unsupported codes yield zero and raise invalid.
// XOR/SLL/SRL/SLT are only decoded when EXEC_EXT_ALU_EN is defined.
module exec_alu_core #(
  parameter int unsigned XLEN = execute_pkg::XLEN
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            invalid
);
  import execute_pkg::*;

  always_comb begin
    result  = '0;
    invalid = 1'b0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
`ifdef EXEC_EXT_ALU_EN
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[5:0];
      ALU_SRL: result = a >> b[5:0];
      ALU_SLT: result = XLEN'($signed(a) < $signed(b));
`endif
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/execute.sv
// Execute stage of the single-cycle RV64 core: ALU, BEQ resolution, next_PC and the PC register.
// Optional extended ALU ops are enabled with the EXEC_EXT_ALU_EN macro.
module execute #(
  parameter int unsigned     XLEN     = execute_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [3:0]      alu_control_signal,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] immediate,
  input  logic            Branch,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] alu_output,
  output logic            zero,
  output logic [XLEN-1:0] next_PC,
  output logic            invALUOp
);
  import execute_pkg::*;

  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] seq_pc;
  logic            branch_taken;

  exec_alu_core #(.XLEN(XLEN)) u_alu (
    .op      (alu_control_signal),
    .a       (rd1),
    .b       (rd2),
    .result  (alu_output),
    .invalid (invALUOp)
  );

  // Immediate is a halfword offset; the shift and add both wrap at XLEN bits.
  always_comb begin
    zero          = (alu_output == '0);
    branch_taken  = Branch & zero;
    branch_target = PC + (immediate << 1);
    seq_pc        = PC + XLEN'(PC_INCR);
    next_PC       = branch_taken ? branch_target : seq_pc;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) PC <= RESET_PC;
    else       PC <= next_PC;
  end

endmodule

// File: tb/tb_execute.sv
// Directed self-checking bench for the execute stage.
module tb_execute;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  alu_control_signal = 4'b0010;
  logic [63:0] rd1 = '0;
  logic [63:0] rd2 = '0;
  logic [63:0] immediate = '0;
  logic        Branch = 1'b0;
  logic [63:0] PC;
  logic [63:0] alu_output;
  logic        zero;
  logic [63:0] next_PC;
  logic        invALUOp;

  int unsigned total = 0;
  int unsigned bad   = 0;

  execute #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .clock              (clock),
    .reset              (reset),
    .alu_control_signal (alu_control_signal),
    .rd1                (rd1),
    .rd2                (rd2),
    .immediate          (immediate),
    .Branch             (Branch),
    .PC                 (PC),
    .alu_output         (alu_output),
    .zero               (zero),
    .next_PC            (next_PC),
    .invALUOp           (invALUOp)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic br, input logic [63:0] imm);
    alu_control_signal = op;
    rd1       = a;
    rd2       = b;
    Branch    = br;
    immediate = imm;
    #1;
  endtask

  // Reset between edges, then advance sequentially n times to reach PC = 4*n.
  task automatic goto_pc(input int unsigned n);
    @(negedge clock);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    set_op(4'b0010, 64'd0, 64'd1, 1'b0, 64'd0);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Asynchronous reset between edges
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset_pc_async", PC, 64'h0);
    tick();
    check("reset_pc_held", PC, 64'h0);
    @(negedge clock);
    reset = 1'b0;
    set_op(4'b0010, 64'd10, 64'd11, 1'b0, 64'd0);
    check("add_result", alu_output, 64'd21);
    check("add_zero", {63'd0, zero}, 64'd0);
    check("add_valid", {63'd0, invALUOp}, 64'd0);
    check("seq_next_pc", next_PC, 64'h4);
    tick();
    check("pc_after_release", PC, 64'h4);

    set_op(4'b0110, 64'd5, 64'd5, 1'b0, 64'd0);
    check("sub_equal", alu_output, 64'd0);
    check("sub_zero", {63'd0, zero}, 64'd1);
    set_op(4'b0000, 64'hC, 64'hA, 1'b0, 64'd0);
    check("and", alu_output, 64'h8);
    set_op(4'b0001, 64'hC, 64'hA, 1'b0, 64'd0);
    check("or", alu_output, 64'hE);
    set_op(4'b0110, 64'd0, 64'd1, 1'b0, 64'd0);
    check("sub_wrap", alu_output, 64'hFFFF_FFFF_FFFF_FFFF);
    set_op(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0);
    check("add_wrap", alu_output, 64'd0);
    check("add_wrap_zero", {63'd0, zero}, 64'd1);

    // Branches from PC = 0x10
    goto_pc(4);
    check("pc_at_0x10", PC, 64'h10);
    set_op(4'b0110, 64'd7, 64'd7, 1'b1, 64'd4);
    check("beq_taken_next", next_PC, 64'h18);
    tick();
    check("beq_taken_pc", PC, 64'h18);

    goto_pc(4);
    set_op(4'b0110, 64'd7, 64'd8, 1'b1, 64'd4);
    check("beq_not_taken_next", next_PC, 64'h14);
    set_op(4'b0110, 64'd7, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    check("beq_back_next", next_PC, 64'h0C);
    tick();
    check("beq_back_pc", PC, 64'h0C);
    set_op(4'b0110, 64'd3, 64'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    check("beq_wrap_next", next_PC, 64'hFFFF_FFFF_FFFF_FFFC);
    set_op(4'b0010, 64'd0, 64'd0, 1'b0, 64'd4);
    check("nobranch_zero_next", next_PC, 64'h10);

    // Unsupported code
    set_op(4'b1111, 64'd9, 64'd3, 1'b0, 64'd0);
    check("inv_flag", {63'd0, invALUOp}, 64'd1);
    check("inv_result", alu_output, 64'd0);
    check("inv_zero", {63'd0, zero}, 64'd1);
    tick();
    check("inv_pc_advance", PC, 64'h10);
    set_op(4'b1111, 64'd9, 64'd3, 1'b1, 64'd8);
    check("inv_branch_taken", next_PC, 64'h20);

`ifdef EXEC_EXT_ALU_EN
    set_op(4'b0100, 64'd1, 64'd63, 1'b0, 64'd0);
    check("sll", alu_output, 64'h8000_0000_0000_0000);
    set_op(4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0);
    check("slt_signed", alu_output, 64'd1);
    set_op(4'b0011, 64'hF, 64'h5, 1'b0, 64'd0);
    check("xor", alu_output, 64'hA);
    set_op(4'b0101, 64'h8000_0000_0000_0000, 64'd63, 1'b0, 64'd0);
    check("srl", alu_output, 64'd1);
`else
    set_op(4'b0011, 64'hF, 64'h5, 1'b0, 64'd0);
    check("xor_unsupported", {63'd0, invALUOp}, 64'd1);
    check("xor_unsupported_res", alu_output, 64'd0);
`endif

    // Reset mid-run returns PC to zero without waiting for an edge
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset_mid_run", PC, 64'h0);
    reset = 1'b0;
    set_op(4'b0010, 64'd1, 64'd1, 1'b0, 64'd0);
    tick();
    check("pc_after_second_reset", PC, 64'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
